// File: rtl/rf_arb_pkg.sv
// Shared widths, grant encoding and address decode for the register-file write-port arbiter.
package rf_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int RF_BE_W    = 4;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef enum logic [0:0] {
      GNT_WB  = 1'b0,
      GNT_MDU = 1'b1
   } gnt_e;

   // r0 is hardwired zero, so it never counts as a pending destination.
   function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] oh;
      oh       = '0;
      oh[addr] = 1'b1;
      oh[0]    = 1'b0;
      return oh;
   endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order buffer of MDU results {waddr, wdata}; exposes per-entry valid/address for hazard tracking.
module rf_arb_fifo
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [REG_ADDR_W-1:0]                push_waddr,
   input  logic [DATA_W-1:0]                    push_wdata,
   input  logic                                 pop,
   output logic                                 full,
   output logic                                 empty,
   output logic [REG_ADDR_W-1:0]                head_waddr,
   output logic [DATA_W-1:0]                    head_wdata,
   output logic [DEPTH-1:0]                     ent_vld,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_waddr
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]                      wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]                      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]                      count;
   logic [PTR_W-1:0]                    wr_idx, rd_idx;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]    addr_q, addr_d;
   logic [DEPTH-1:0][DATA_W-1:0]        data_q, data_d;

   assign wr_idx     = wr_ptr_q[PTR_W-1:0];
   assign rd_idx     = rd_ptr_q[PTR_W-1:0];
   assign count      = wr_ptr_q - rd_ptr_q;
   assign empty      = (wr_ptr_q == rd_ptr_q);
   // The extra pointer bit makes count reach exactly DEPTH when full.
   assign full       = count[PTR_W];
   assign head_waddr = addr_q[rd_idx];
   assign head_wdata = data_q[rd_idx];
   assign ent_waddr  = addr_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_vld[i] = ({1'b0, PTR_W'(i) - rd_idx} < count);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (push && !full) begin
         addr_d[wr_idx] = push_waddr;
         data_d[wr_idx] = push_wdata;
         wr_ptr_d       = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, buffered MDU results retire in idle/WAW cycles.
// Optional starvation guard enabled by defining RF_ARB_STARVE_GUARD_EN.
module rf_wport_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_valid,
   input  logic [RF_BE_W-1:0]      wb_rf_we,
   input  logic [REG_ADDR_W-1:0]   wb_waddr,
   input  logic [DATA_W-1:0]       wb_wdata,
   output logic                    wb_ready,
   input  logic                    mdu_valid,
   input  logic [REG_ADDR_W-1:0]   mdu_waddr,
   input  logic [DATA_W-1:0]       mdu_wdata,
   output logic                    mdu_ready,
   output logic [RF_BE_W-1:0]      rf_we,
   output logic [REG_ADDR_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0]       rf_wdata,
   output logic [NUM_REGS-1:0]     pend_mask
);

   logic                               wb_req, conflict, forced;
   logic                               grant_mdu, grant_wb, push;
   logic                               fifo_full, fifo_empty;
   logic [REG_ADDR_W-1:0]              head_waddr;
   logic [DATA_W-1:0]                  head_wdata;
   logic [DEPTH-1:0]                   ent_vld;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_waddr;
   gnt_e                               state_q, state_d;
   logic                               unused_obs;

   assign mdu_ready = !fifo_full;
   assign push      = mdu_valid && !fifo_full && (mdu_waddr != '0);

   rf_arb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_waddr (mdu_waddr),
      .push_wdata (mdu_wdata),
      .pop        (grant_mdu),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_waddr (head_waddr),
      .head_wdata (head_wdata),
      .ent_vld    (ent_vld),
      .ent_waddr  (ent_waddr)
   );

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pend_mask = pend_mask | addr_onehot(ent_waddr[i]);
      end
   end

   // Buffered results are older than WB, so a WAW match must drain first.
   assign wb_req    = wb_valid && (wb_rf_we != '0);
   assign conflict  = wb_req && pend_mask[wb_waddr];
   assign grant_mdu = !fifo_empty && (!wb_req || conflict || forced);
   assign grant_wb  = wb_req && !grant_mdu;
   assign wb_ready  = !(conflict || forced);

   always_comb begin
      rf_we    = '0;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
      if (grant_mdu) begin
         rf_we    = '1;
         rf_waddr = head_waddr;
         rf_wdata = head_wdata;
      end else if (grant_wb) begin
         rf_we    = wb_rf_we;
      end
   end

   assign state_d = grant_mdu ? GNT_MDU : GNT_WB;

   always_ff @(posedge clk) begin
      if (reset) state_q <= GNT_WB;
      else       state_q <= state_d;
   end

`ifdef RF_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign forced = !fifo_empty && (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (fifo_empty || grant_mdu) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end

   // Grant state is kept for debug visibility only.
   assign unused_obs = (state_q == GNT_MDU);
`else
   assign forced     = 1'b0;
   assign unused_obs = (state_q == GNT_MDU) ^ (STARVE_LIMIT == 0);
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_rf_wport_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_rf_we = '0;
   logic [4:0]  wb_waddr = '0;
   logic [31:0] wb_wdata = '0;
   logic        wb_ready;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_waddr = '0;
   logic [31:0] mdu_wdata = '0;
   logic        mdu_ready;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pend_mask;

   always #5 clk = ~clk;

   rf_wport_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_rf_we  (wb_rf_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .wb_ready  (wb_ready),
      .mdu_valid (mdu_valid),
      .mdu_waddr (mdu_waddr),
      .mdu_wdata (mdu_wdata),
      .mdu_ready (mdu_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pend_mask (pend_mask)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   int   starve = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   logic [3:0]  o_we;
   logic [4:0]  o_wa;
   logic [31:0] o_wd, o_pend;
   logic        o_wbr, o_mr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model at the edge.
   task automatic step(input logic rst_i, input logic wbv, input logic [3:0] we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] ma, input logic [31:0] md);
      logic        e_mr, wbreq, conf, frc, gm, gw;
      logic [31:0] e_pend, e_wd;
      logic [3:0]  e_we;
      logic [4:0]  e_wa;
      @(negedge clk);
      reset = rst_i; wb_valid = wbv; wb_rf_we = we; wb_waddr = wa; wb_wdata = wd;
      mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
      #1;
      o_we = rf_we; o_wa = rf_waddr; o_wd = rf_wdata; o_pend = pend_mask;
      o_wbr = wb_ready; o_mr = mdu_ready;
      e_mr   = (mq.size() < DEPTH);
      wbreq  = wbv && (we != 4'h0);
      e_pend = '0;
      conf   = 1'b0;
      foreach (mq[i]) begin
         e_pend[mq[i].a] = 1'b1;
         if (wbreq && mq[i].a == wa) conf = 1'b1;
      end
      frc = 1'b0;
`ifdef RF_ARB_STARVE_GUARD_EN
      frc = (mq.size() > 0) && (starve >= STARVE_LIMIT);
`endif
      gm   = (mq.size() > 0) && (!wbreq || conf || frc);
      gw   = wbreq && !gm;
      e_we = gm ? 4'hF : (gw ? we : 4'h0);
      e_wa = wa;
      e_wd = wd;
      if (gm) begin
         e_wa = mq[0].a;
         e_wd = mq[0].d;
      end
      if (!rst_i) begin
         check("rf_we", {28'h0, o_we}, {28'h0, e_we});
         check("pend_mask", o_pend, e_pend);
         check("mdu_ready", {31'h0, o_mr}, {31'h0, e_mr});
         check("wb_ready", {31'h0, o_wbr}, {31'h0, !(conf || frc)});
         if (e_we != 4'h0) begin
            check("rf_waddr", {27'h0, o_wa}, {27'h0, e_wa});
            check("rf_wdata", o_wd, e_wd);
         end
      end
      @(posedge clk);
      if (rst_i) begin
         mq.delete();
         starve = 0;
      end else begin
         if (mq.size() == 0 || gm) starve = 0;
         else                      starve++;
         if (gm) void'(mq.pop_front());
         if (mv && e_mr && ma != 5'd0) mq.push_back('{ma, md});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      do_reset();
      do_reset();

      // Reset state
      idle(1);
      check("rst_we", {28'h0, o_we}, 32'h0);
      check("rst_pend", o_pend, 32'h0);
      check("rst_mready", {31'h0, o_mr}, 32'h1);
      check("rst_wbready", {31'h0, o_wbr}, 32'h1);

      // Single MDU result with WB idle retires one cycle later
      step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
      check("t1_acc_ready", {31'h0, o_mr}, 32'h1);
      check("t1_no_early_we", {28'h0, o_we}, 32'h0);
      idle(1);
      check("t1_we", {28'h0, o_we}, 32'hF);
      check("t1_waddr", {27'h0, o_wa}, 32'd5);
      check("t1_wdata", o_wd, 32'h1234);
      check("t1_pend", o_pend, 32'h20);
      idle(1);
      check("t1_pend_clr", o_pend, 32'h0);
      check("t1_we_after", {28'h0, o_we}, 32'h0);

      // WB busy on r3, MDU floods r7: fifth push sees full
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 4'hF, 5'd3, 32'hA000 + k, 1'b1, 5'd7, 32'hB000 + k);
         check("t2_mready", {31'h0, o_mr}, (k < 4) ? 32'h1 : 32'h0);
         check("t2_wb_waddr", {27'h0, o_wa}, 32'd3);
         check("t2_wb_data", o_wd, 32'hA000 + k);
         check("t2_wb_ready", {31'h0, o_wbr}, 32'h1);
      end

      // WAW on r9: buffered MDU result first, then WB
      do_reset();
      step(1'b0, 1'b1, 4'hF, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
      step(1'b0, 1'b1, 4'hF, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0);
      check("t3_stall", {31'h0, o_wbr}, 32'h0);
      check("t3_mdu_waddr", {27'h0, o_wa}, 32'd9);
      check("t3_mdu_wdata", o_wd, 32'h99);
      step(1'b0, 1'b1, 4'hF, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0);
      check("t3_wb_go", {31'h0, o_wbr}, 32'h1);
      check("t3_wb_wdata", o_wd, 32'h77);
      check("t3_wb_waddr", {27'h0, o_wa}, 32'd9);

      // Writes to r0 are accepted and dropped
      do_reset();
      step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
      check("t4_mready", {31'h0, o_mr}, 32'h1);
      idle(1);
      check("t4_no_we", {28'h0, o_we}, 32'h0);
      check("t4_pend", o_pend, 32'h0);

      // One entry on r4 under continuous WB traffic
      do_reset();
      step(1'b0, 1'b1, 4'hF, 5'd1, 32'h0, 1'b1, 5'd4, 32'h44);
      for (int c = 1; c <= 12; c++) begin
         step(1'b0, 1'b1, 4'hF, 5'd1, 32'h100 + c, 1'b0, 5'd0, 32'h0);
`ifdef RF_ARB_STARVE_GUARD_EN
         check("t5_wb_ready", {31'h0, o_wbr}, (c == 9) ? 32'h0 : 32'h1);
         check("t5_pend", o_pend, (c <= 9) ? 32'h10 : 32'h0);
         if (c == 9) check("t5_forced_waddr", {27'h0, o_wa}, 32'd4);
`else
         check("t5_wb_ready", {31'h0, o_wbr}, 32'h1);
         check("t5_pend", o_pend, 32'h10);
         check("t5_wb_waddr", {27'h0, o_wa}, 32'd1);
`endif
      end

      // Reset with three pending entries flushes them
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'hF, 5'd1, 32'h0, 1'b1, 5'(10 + k), 32'hC0 + k);
      check("t6_pend_before", o_pend, 32'h0000_0C00);
      do_reset();
      idle(1);
      check("t6_pend", o_pend, 32'h0);
      check("t6_we", {28'h0, o_we}, 32'h0);
      check("t6_mready", {31'h0, o_mr}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         check("t6_no_stale", {28'h0, o_we}, 32'h0);
      end

      // Random traffic with small address range to provoke conflicts
      for (int n = 0; n < 3000; n++) begin
         logic        r_rst, r_wbv, r_mv;
         logic [3:0]  r_we;
         r_rst = ($urandom_range(0, 199) == 0);
         r_wbv = $urandom_range(0, 1);
         r_we  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         r_mv  = ($urandom_range(0, 2) != 0);
         step(r_rst, r_wbv, r_we, 5'($urandom_range(0, 7)), $urandom,
              r_mv, 5'($urandom_range(0, 7)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
